uart_tx: RTL and testbench

Serial transmitter that sits directly downstream of the free-running tick timer and consumes its one-cycle `pulse_out` as the baud-rate enable. It accepts a parallel byte over a valid/ready handshake. It then shifts out a standard asynchronous frame on `tx`: start bit, data LSB first, optional parity, then stop bit(s). Every bit boundary is aligned to a tick.

---
 rtl/uart_tx.sv | 131 +++++++++++++
 tb/tb_uart_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Asynchronous serial transmitter paced by an external baud tick.
// Frames are start, LSB-first data, optional parity, then stop bit(s).
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic ODD = 1'(PARITY_ODD);
  localparam bit PEN = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 stop_q, stop_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      shreg_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          shreg_d = tx_data;
          par_d   = (^tx_data) ^ ODD;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_q == LAST_BIT) begin
            stop_d = 1'b0;
            if (PEN) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_q == LAST_STOP) begin
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx across default, parity, two-stop
// and five-bit configurations.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [4:0] txv, rdyv, bsyv;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx u0 (
    .clk(clk), .rst(rst), .tick(tick),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdyv[0]), .tx(txv[0]), .busy(bsyv[0])
  );
  uart_tx #(.PARITY_EN(1)) u1 (
    .clk(clk), .rst(rst), .tick(tick),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdyv[1]), .tx(txv[1]), .busy(bsyv[1])
  );
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst(rst), .tick(tick),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdyv[2]), .tx(txv[2]), .busy(bsyv[2])
  );
  uart_tx #(.STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tick(tick),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdyv[3]), .tx(txv[3]), .busy(bsyv[3])
  );
  uart_tx #(.DATA_BITS(5)) u4 (
    .clk(clk), .rst(rst), .tick(tick),
    .tx_data(tx_data[4:0]), .tx_valid(tx_valid),
    .tx_ready(rdyv[4]), .tx(txv[4]), .busy(bsyv[4])
  );

  // Inputs change at a negedge; outputs are sampled at the next negedge.
  task automatic cycle(input logic t);
    tick = t;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tx_valid = 1'b0;
    cycle(1'b0);
    rst = 1'b0;
  endtask

  task automatic accept(input int u, input logic [7:0] d,
                        input logic t, input string nm);
    tx_data = d;
    tx_valid = 1'b1;
    cycle(t);
    tx_valid = 1'b0;
    checks++;
    if (rdyv[u] !== 1'b0 || bsyv[u] !== 1'b1 || txv[u] !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: ready=%b busy=%b tx=%b, want 0 1 1",
               nm, rdyv[u], bsyv[u], txv[u]);
    end
  endtask

  // gap = idle cycles before the tick that launches the start bit
  task automatic shift_frame(input int u, input string pat,
                             input int gap, input string nm);
    byte  c;
    logic e;
    for (int i = 0; i < gap; i++) begin
      checks++;
      if (txv[u] !== 1'b1 || rdyv[u] !== 1'b0) begin
        errors++;
        $display("FAIL %s gap%0d: tx=%b ready=%b, want 1 0",
                 nm, i, txv[u], rdyv[u]);
      end
      cycle(1'b0);
    end
    cycle(1'b1);
    for (int k = 0; k < pat.len(); k++) begin
      c = pat[k];
      e = (c == "1");
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (txv[u] !== e || rdyv[u] !== 1'b0 || bsyv[u] !== 1'b1) begin
          errors++;
          $display("FAIL %s bit%0d cyc%0d: tx=%b ready=%b busy=%b, want %b 0 1",
                   nm, k, j, txv[u], rdyv[u], bsyv[u], e);
        end
        cycle(j == 3);
      end
    end
    checks++;
    if (rdyv[u] !== 1'b1 || bsyv[u] !== 1'b0 || txv[u] !== 1'b1) begin
      errors++;
      $display("FAIL %s end: ready=%b busy=%b tx=%b, want 1 0 1",
               nm, rdyv[u], bsyv[u], txv[u]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    checks++;
    if (txv !== 5'h1f || rdyv !== 5'h1f || bsyv !== 5'h00) begin
      errors++;
      $display("FAIL reset: tx=%b ready=%b busy=%b, want 11111 11111 00000",
               txv, rdyv, bsyv);
    end
    rst = 1'b0;
  endtask

  task automatic test_frame();
    pulse_rst();
    accept(0, 8'hA5, 1'b0, "a5");
    shift_frame(0, "0101001011", 0, "a5");
  endtask

  task automatic test_parity();
    pulse_rst();
    accept(1, 8'hA5, 1'b0, "a5_even");
    shift_frame(1, "01010010101", 0, "a5_even");
    pulse_rst();
    accept(2, 8'hA5, 1'b0, "a5_odd");
    shift_frame(2, "01010010111", 0, "a5_odd");
    pulse_rst();
    accept(1, 8'h07, 1'b0, "07_even");
    shift_frame(1, "01110000011", 0, "07_even");
  endtask

  task automatic test_back_to_back();
    pulse_rst();
    tx_data = 8'h00;
    tx_valid = 1'b1;
    cycle(1'b0);
    tx_data = 8'hFF;
    checks++;
    if (rdyv[3] !== 1'b0) begin
      errors++;
      $display("FAIL b2b accept0: ready=%b, want 0", rdyv[3]);
    end
    shift_frame(3, "00000000011", 0, "b2b_00");
    cycle(1'b0);
    tx_valid = 1'b0;
    checks++;
    if (rdyv[3] !== 1'b0 || txv[3] !== 1'b1) begin
      errors++;
      $display("FAIL b2b accept1: ready=%b tx=%b, want 0 1",
               rdyv[3], txv[3]);
    end
    shift_frame(3, "01111111111", 2, "b2b_ff");
  endtask

  task automatic test_tick_edges();
    pulse_rst();
    cycle(1'b1);
    checks++;
    if (txv[0] !== 1'b1 || bsyv[0] !== 1'b0 || rdyv[0] !== 1'b1) begin
      errors++;
      $display("FAIL idle_tick: tx=%b busy=%b ready=%b, want 1 0 1",
               txv[0], bsyv[0], rdyv[0]);
    end
    accept(0, 8'hC3, 1'b1, "tick_acc");
    shift_frame(0, "0110000111", 3, "tick_acc");
  endtask

  task automatic test_reset_mid();
    pulse_rst();
    accept(0, 8'h5A, 1'b0, "rst_mid");
    cycle(1'b1);
    for (int p = 0; p < 3; p++) begin
      cycle(1'b0); cycle(1'b0); cycle(1'b0); cycle(1'b1);
    end
    checks++;
    if (txv[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid d2: tx=%b, want 0", txv[0]);
    end
    cycle(1'b0); cycle(1'b0); cycle(1'b0); cycle(1'b1);
    checks++;
    if (txv[0] !== 1'b1 || bsyv[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid d3: tx=%b busy=%b, want 1 1",
               txv[0], bsyv[0]);
    end
    rst = 1'b1;
    cycle(1'b0);
    rst = 1'b0;
    checks++;
    if (txv[0] !== 1'b1 || bsyv[0] !== 1'b0 || rdyv[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid abort: tx=%b busy=%b ready=%b, want 1 0 1",
               txv[0], bsyv[0], rdyv[0]);
    end
    accept(0, 8'h3C, 1'b0, "after_rst");
    shift_frame(0, "0001111001", 0, "after_rst");
  endtask

  task automatic test_data5();
    pulse_rst();
    accept(4, 8'h1F, 1'b0, "d5_1f");
    shift_frame(4, "0111111", 0, "d5_1f");
    pulse_rst();
    accept(4, 8'hF5, 1'b0, "d5_f5");
    shift_frame(4, "0101011", 0, "d5_f5");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame();
    test_parity();
    test_back_to_back();
    test_tick_edges();
    test_reset_mid();
    test_data5();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
